// File: rtl/bcd_pkg.sv
// Shared constants and helpers for BCD display counters.
// Parameter legality is checked at elaboration by the blocks that import this package.
package bcd_pkg;

    localparam int unsigned BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef logic [BCD_W-1:0] bcd_t;

    // Two-digit BCD image of a small integer (0..99), {tens, units}.
    function automatic logic [2*BCD_W-1:0] to_bcd2(input int unsigned value);
        bcd_t tens;
        bcd_t units;
        tens  = BCD_W'(value / 10);
        units = BCD_W'(value % 10);
        return {tens, units};
    endfunction

    function automatic bit params_legal(input int unsigned clk_hz, input int unsigned tick_hz,
                                        input int unsigned modulus, input int unsigned ext_tick);
        return (tick_hz != 0) && (clk_hz >= tick_hz) && (clk_hz % tick_hz == 0) &&
               (modulus >= 2) && (modulus <= 100) && (ext_tick <= 1);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divide-by-(CLK_HZ/TICK_HZ) strobe generator with count enable.
// The strobe is combinational off the phase counter so DIV=1 gives a tick every enabled cycle.
module tick_prescaler #(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 1
) (
    input  logic clk,
    input  logic rs,
    input  logic en,
    output logic tick
);

    localparam int unsigned DIV = (TICK_HZ == 0) ? 1 : CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    if ((TICK_HZ == 0) || (CLK_HZ < TICK_HZ) || (CLK_HZ % TICK_HZ != 0)) begin : g_div_err
        $error("tick_prescaler: CLK_HZ/TICK_HZ must be an exact integer >= 1");
    end

    logic [PW-1:0] pcnt_q, pcnt_d;

    assign tick = en && (pcnt_q == LAST);

    always_comb begin
        pcnt_d = pcnt_q;
        if (en) begin
            pcnt_d = tick ? '0 : pcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rs) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/bcd_modn_counter.sv
// Two-digit BCD modulo-N up/down counter with prescaler, synchronous load and
// a registered carry/borrow pulse for cascading display stages.
module bcd_modn_counter
    import bcd_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned TICK_HZ  = 1,
    parameter int unsigned MODULUS  = 60,
    parameter int unsigned EXT_TICK = 0
) (
    input  logic             clk,
    input  logic             rs,
    input  logic             en,
    input  logic             up,
    input  logic             tick_in,
    input  logic             load,
    input  logic [BCD_W-1:0] load_lo,
    input  logic [BCD_W-1:0] load_hi,
    output logic [BCD_W-1:0] led1,
    output logic [BCD_W-1:0] led2,
    output logic             tick_out,
    output logic             co,
    output logic             load_err
);

    if (!params_legal(CLK_HZ, TICK_HZ, MODULUS, EXT_TICK)) begin : g_param_err
        $error("bcd_modn_counter: illegal CLK_HZ/TICK_HZ/MODULUS/EXT_TICK combination");
    end

    localparam logic [2*BCD_W-1:0] TOP = to_bcd2(MODULUS - 1);
    localparam bcd_t TOP_HI = TOP[2*BCD_W-1:BCD_W];
    localparam bcd_t TOP_LO = TOP[BCD_W-1:0];

    logic adv;

    if (EXT_TICK != 0) begin : g_ext_tick
        assign tick_out = tick_in;
        assign adv      = tick_in & en;
    end else begin : g_int_tick
        logic unused_tick_in;
        assign unused_tick_in = tick_in;

        tick_prescaler #(
            .CLK_HZ  (CLK_HZ),
            .TICK_HZ (TICK_HZ)
        ) u_prescaler (
            .clk  (clk),
            .rs   (rs),
            .en   (en),
            .tick (tick_out)
        );
        assign adv = tick_out;
    end

    bcd_t lo_q, lo_d;
    bcd_t hi_q, hi_d;
    logic co_q, co_d;
    logic err_q, err_d;

    // 15*10+15 fits in 8 bits, so out-of-range digits cannot alias into range.
    logic [7:0] load_val;
    logic       load_ok;

    assign load_val = {4'b0, load_hi} * 8'd10 + {4'b0, load_lo};
    assign load_ok  = (load_lo <= BCD_MAX) && (load_hi <= BCD_MAX) &&
                      (load_val < 8'(MODULUS));

    always_comb begin
        lo_d  = lo_q;
        hi_d  = hi_q;
        co_d  = 1'b0;
        err_d = 1'b0;
        if (load) begin
            if (load_ok) begin
                lo_d = load_lo;
                hi_d = load_hi;
            end else begin
                err_d = 1'b1;
            end
        end else if (adv) begin
            if (up) begin
                if ((hi_q == TOP_HI) && (lo_q == TOP_LO)) begin
                    lo_d = '0;
                    hi_d = '0;
                    co_d = 1'b1;
                end else if (lo_q == BCD_MAX) begin
                    lo_d = '0;
                    hi_d = hi_q + 1'b1;
                end else begin
                    lo_d = lo_q + 1'b1;
                end
            end else begin
                if ((hi_q == '0) && (lo_q == '0)) begin
                    lo_d = TOP_LO;
                    hi_d = TOP_HI;
                    co_d = 1'b1;
                end else if (lo_q == '0) begin
                    lo_d = BCD_MAX;
                    hi_d = hi_q - 1'b1;
                end else begin
                    lo_d = lo_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rs) begin
            lo_q  <= '0;
            hi_q  <= '0;
            co_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            lo_q  <= lo_d;
            hi_q  <= hi_d;
            co_q  <= co_d;
            err_q <= err_d;
        end
    end

    assign led1     = lo_q;
    assign led2     = hi_q;
    assign co       = co_q;
    assign load_err = err_q;

endmodule

// File: tb/tb_bcd_modn_counter.sv
// Bench for bcd_modn_counter: an internal-prescaler mod-60 instance and an external-tick
// mod-24 instance, both checked every cycle against an integer-valued reference model.
module tb_bcd_modn_counter;

    localparam int DIV_A = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rs, a_en, a_up, a_tin, a_load;
    logic [3:0] a_lo, a_hi, a_led1, a_led2;
    logic       a_tick, a_co, a_err;

    logic       b_rs, b_en, b_up, b_tin, b_load;
    logic [3:0] b_lo, b_hi, b_led1, b_led2;
    logic       b_tick, b_co, b_err;

    bcd_modn_counter #(
        .CLK_HZ   (8),
        .TICK_HZ  (2),
        .MODULUS  (60),
        .EXT_TICK (0)
    ) dut_a (
        .clk      (clk),
        .rs       (a_rs),
        .en       (a_en),
        .up       (a_up),
        .tick_in  (a_tin),
        .load     (a_load),
        .load_lo  (a_lo),
        .load_hi  (a_hi),
        .led1     (a_led1),
        .led2     (a_led2),
        .tick_out (a_tick),
        .co       (a_co),
        .load_err (a_err)
    );

    bcd_modn_counter #(
        .CLK_HZ   (8),
        .TICK_HZ  (2),
        .MODULUS  (24),
        .EXT_TICK (1)
    ) dut_b (
        .clk      (clk),
        .rs       (b_rs),
        .en       (b_en),
        .up       (b_up),
        .tick_in  (b_tin),
        .load     (b_load),
        .load_lo  (b_lo),
        .load_hi  (b_hi),
        .led1     (b_led1),
        .led2     (b_led2),
        .tick_out (b_tick),
        .co       (b_co),
        .load_err (b_err)
    );

    int tests = 0;
    int fails = 0;

    // Reference state: the counter value as a plain integer, prescaler phase, pulses.
    int av = 0, aph = 0, bv = 0;
    bit aco = 0, aerr = 0, bco = 0, berr = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit rs, input bit adv, input bit ld, input bit up,
                         input int lo, input int hi, input int m,
                         inout int v, inout bit co, inout bit err);
        co  = 0;
        err = 0;
        if (rs) begin
            v = 0;
        end else if (ld) begin
            if (lo <= 9 && hi <= 9 && hi * 10 + lo < m) v = hi * 10 + lo;
            else err = 1;
        end else if (adv) begin
            if (up) begin
                co = (v == m - 1);
                v  = (v + 1) % m;
            end else begin
                co = (v == 0);
                v  = (v + m - 1) % m;
            end
        end
    endtask

    task automatic cycle();
        bit a_adv;
        a_adv = a_en && (aph == DIV_A - 1);
        #1;
        chk("a_tick_out", 8'(a_tick), 8'(a_adv));
        chk("b_tick_out", 8'(b_tick), 8'(b_tin));
        @(posedge clk);
        if (a_rs) aph = 0;
        else if (a_en) aph = (aph + 1) % DIV_A;
        model(a_rs, a_adv, a_load, a_up, int'(a_lo), int'(a_hi), 60, av, aco, aerr);
        model(b_rs, b_tin && b_en, b_load, b_up, int'(b_lo), int'(b_hi), 24, bv, bco, berr);
        #1;
        chk("a_led1", 8'(a_led1), 8'(av % 10));
        chk("a_led2", 8'(a_led2), 8'(av / 10));
        chk("a_co", 8'(a_co), 8'(aco));
        chk("a_load_err", 8'(a_err), 8'(aerr));
        chk("b_led1", 8'(b_led1), 8'(bv % 10));
        chk("b_led2", 8'(b_led2), 8'(bv / 10));
        chk("b_co", 8'(b_co), 8'(bco));
        chk("b_load_err", 8'(b_err), 8'(berr));
    endtask

    initial begin
        a_rs = 1; a_en = 0; a_up = 1; a_tin = 0; a_load = 0; a_lo = 0; a_hi = 0;
        b_rs = 1; b_en = 0; b_up = 1; b_tin = 0; b_load = 0; b_lo = 0; b_hi = 0;
        cycle();
        cycle();
        chk("reset_a", {a_led2, a_led1}, 8'h00);
        a_rs = 0; b_rs = 0;

        // Up-count through a full wrap 59 -> 00.
        a_en = 1; a_up = 1;
        repeat (DIV_A * 61) cycle();

        // Loads: accepted, rejected by modulus, rejected by non-BCD digit.
        while (aph != 0) cycle();
        a_load = 1; a_hi = 4; a_lo = 5; cycle();
        chk("load_45", {a_led2, a_led1}, 8'h45);
        a_hi = 6; a_lo = 0; cycle();
        chk("load_60_err", 8'(a_err), 8'd1);
        a_hi = 0; a_lo = 4'hA; cycle();
        chk("load_0A_err", 8'(a_err), 8'd1);
        a_load = 0;

        // Load coincides with adv while showing 59: load wins, no carry.
        while (aph != 0) cycle();
        a_load = 1; a_hi = 5; a_lo = 9; cycle();
        a_load = 0;
        while (aph != DIV_A - 1) cycle();
        a_load = 1; a_hi = 1; a_lo = 2; cycle();
        chk("load_beats_adv", {a_led2, a_led1}, 8'h12);
        chk("load_beats_adv_co", 8'(a_co), 8'd0);
        a_load = 0;

        // Enable dropped mid-prescale, then resumed.
        while (aph != 2) cycle();
        a_en = 0; repeat (10) cycle();
        a_en = 1; repeat (8) cycle();

        // Reset at 37 with a tick pending.
        while (aph != 0) cycle();
        a_load = 1; a_hi = 3; a_lo = 7; cycle();
        a_load = 0;
        while (aph != DIV_A - 1) cycle();
        a_rs = 1; cycle();
        chk("reset_at_37", {a_led2, a_led1}, 8'h00);
        a_rs = 0; repeat (6) cycle();

        // External-tick instance, mod 24 counting down from 00.
        b_en = 1; b_up = 0; b_load = 1; b_hi = 0; b_lo = 0; cycle();
        b_load = 0; b_tin = 1; cycle();
        chk("down_wrap_23", {b_led2, b_led1}, 8'h23);
        chk("down_wrap_co", 8'(b_co), 8'd1);
        b_tin = 0; cycle();
        b_tin = 1; cycle();
        chk("down_22", {b_led2, b_led1}, 8'h22);
        chk("down_22_co", 8'(b_co), 8'd0);
        b_en = 0; cycle();
        b_en = 1; b_tin = 0; b_up = 1;
        repeat (6) begin
            b_tin = 1; cycle();
            b_tin = 0; cycle();
        end

        // Randomised traffic on both instances.
        repeat (600) begin
            a_rs   = ($urandom_range(0, 63) == 0);
            a_en   = ($urandom_range(0, 7) != 0);
            a_up   = 1'($urandom_range(0, 1));
            a_tin  = 1'($urandom_range(0, 1));
            a_load = ($urandom_range(0, 15) == 0);
            a_lo   = 4'($urandom_range(0, 11));
            a_hi   = 4'($urandom_range(0, 7));
            b_rs   = ($urandom_range(0, 63) == 0);
            b_en   = ($urandom_range(0, 7) != 0);
            b_up   = 1'($urandom_range(0, 1));
            b_tin  = 1'($urandom_range(0, 1));
            b_load = ($urandom_range(0, 15) == 0);
            b_lo   = 4'($urandom_range(0, 11));
            b_hi   = 4'($urandom_range(0, 3));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd_modn_counter.md
Name: bcd_modn_counter

Overview:
- Parametrised successor to the fixed mod-60 display counter: a two-digit BCD counter with configurable modulus.
- Has an integrated tick prescaler, up/down mode, synchronous BCD load, and a carry/borrow pulse so instances cascade (seconds -> minutes -> hours).
- Sits between the board clock and the 7-segment/LED digit drivers; replaces the separate 1 Hz divider plus mod-60 pair.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency in Hz.
- TICK_HZ, 1, count rate in Hz. DIV = CLK_HZ/TICK_HZ; legal only if DIV >= 1 and the division is exact.
- MODULUS, 60, count range 00..MODULUS-1. Legal 2..100.
- EXT_TICK, 0, selection of the count source:
  - 1: prescaler bypassed; the counter advances on tick_in.
  - 0: internal prescaler used; tick_in ignored.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rs  in  1  reset, synchronous, active-high; one clock, all state.
- en  in  1  count enable; when low, ticks are ignored and the prescaler holds.
- up  in  1  direction: 1 = increment, 0 = decrement.
- tick_in  in  1  external advance strobe, one cycle wide; used only when EXT_TICK=1.
- load  in  1  synchronous load strobe.
- load_lo  in  4  BCD units value to load.
- load_hi  in  4  BCD tens value to load.
- led1  out  4  BCD units digit.
- led2  out  4  BCD tens digit.
- tick_out  out  1  one-cycle strobe when the prescaler expires (ungated by en in EXT_TICK=1 mode).
- co  out  1  one-cycle carry (up) or borrow (down) pulse on wrap.
- load_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (rs=1 at an edge): led1=0, led2=0, co=0, tick_out=0, load_err=0, prescaler count=0. Reset has priority over everything.
- Prescaler (EXT_TICK=0):
  - pcnt counts 0..DIV-1 while en=1; holds while en=0.
  - tick_out=1 in the cycle where pcnt==DIV-1; pcnt then returns to 0.
  - DIV=1: tick_out is high every enabled cycle.
- Advance event adv:
  - EXT_TICK=0: adv = tick_out.
  - EXT_TICK=1: adv = tick_in & en, with tick_out = tick_in.
- Priority per cycle: rs > load > adv > hold.
- Load:
  - Accepted if load_lo<=9, load_hi<=9, and 10*load_hi+load_lo < MODULUS.
  - Accepted: digits take the load values next cycle.
  - Rejected: digits hold and load_err=1 for one cycle.
  - A load in the same cycle as adv wins; the adv is discarded and co stays 0. The prescaler is unaffected by load.
- Up count on adv:
  - Units increment; at 9, units go to 0 and tens increment.
  - At value MODULUS-1, both digits go to 0 and co=1 in the same cycle the display shows 00 (registered, latency 1 from adv).
- Down count on adv:
  - Units decrement; at 0, units go to 9 and tens decrement.
  - At 00, digits go to MODULUS-1 in BCD and co=1 in the cycle the new value is shown.
- co is never asserted outside a wrap; co width is exactly one clock per wrap.
- Direction change takes effect on the next adv; no glitch or extra count.
- Internal state is a pair of 4-bit BCD digits, never binary. Tens never exceed (MODULUS-1)/10; units never exceed 9.
- en=0 blocks adv but does not block load.
- Reset asserted mid-prescale discards the partial count.

Decomposition:
- Shared package bcd_pkg:
  - BCD digit width constant (4).
  - Constant BCD_MAX=9.
  - Function to_bcd2(int) returning {tens, units}, used for the MODULUS-1 wrap value.
  - Elaboration-time checks on parameter legality.
- One sub-module, tick_prescaler (parameters CLK_HZ, TICK_HZ; ports clk, rs, en, tick). Reusable by other display blocks.
- The counter core stays in bcd_modn_counter.

Test Plan:
- CLK_HZ=8, TICK_HZ=2 (DIV=4), MODULUS=60, en=1, up=1 after reset -> tick_out every 4th cycle; digits step 00,01,...,09,10; at 59 the next tick gives 00 with co=1 for exactly one cycle.
- MODULUS=24, up=0, load 00 then tick -> 23 (led2=2, led1=3) with co=1; next tick -> 22 with co=0.
- Load 4/5 (45) with MODULUS=60 -> next cycle 45, load_err=0. Load hi=6, lo=0 -> digits hold, load_err=1. Load lo=A -> rejected, load_err=1.
- load and adv asserted in the same cycle at value 59 -> digits show the loaded value; co=0.
- en=0 for 10 cycles mid-prescale -> digits and pcnt frozen; counting resumes at the held phase when en returns to 1.
- rs=1 asserted while the value is 37 with a tick pending -> next cycle all outputs 0; first tick_out occurs DIV cycles after rs is released. Also check EXT_TICK=1: tick_in pulses advance one count each.
